// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks in-flight destinations for the integer and
// FP register files, gates instruction issue on RAW/WAW hazards, and arbitrates
// three write-back requesters (ALU, FPU, MEM) onto a single registered
// register-file write port.
module regfile_scoreboard #(
    parameter int ROUND_ROBIN = 0
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs1_f,
    input  logic        issue_rs2_f,
    input  logic        issue_rs1_used,
    input  logic        issue_rs2_used,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_f,
    input  logic        issue_rd_used,
    output logic        issue_ready,

    input  logic [2:0]  wb_valid,
    input  logic [2:0]  wb_f,
    input  logic [14:0] wb_reg,
    input  logic [95:0] wb_data,
    output logic [2:0]  wb_grant,

    output logic        rf_wenable,
    output logic        rf_wfmode,
    output logic [4:0]  rf_wreg,
    output logic [31:0] rf_wdata,
    output logic        idle
);

    // Busy bits: one per architectural register in each file.
    logic [31:0] gbusy_q, gbusy_d;
    logic [31:0] fbusy_q, fbusy_d;

    // Round-robin pointer naming the highest-priority requester (0..2).
    logic [1:0]  rr_ptr_q, rr_ptr_d;

    // Registered register-file write port and idle flag.
    logic        rf_wenable_q, rf_wenable_d;
    logic        rf_wfmode_q,  rf_wfmode_d;
    logic [4:0]  rf_wreg_q,    rf_wreg_d;
    logic [31:0] rf_wdata_q,   rf_wdata_d;
    logic        idle_q,       idle_d;

    // Hazard and arbitration intermediates.
    logic        rs1_hazard;
    logic        rs2_hazard;
    logic        rd_hazard;
    logic        issue_fire;
    logic [2:0]  fixed_grant;
    logic [2:0]  rr_grant;
    logic        grant_any;
    logic [1:0]  grant_idx;
    logic        sel_f;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    // Hazard detection looks only at the registered busy state, so a write-back
    // retiring this cycle does not unblock a dependent until the following one.
    always_comb begin
        rs1_hazard = 1'b0;
        rs2_hazard = 1'b0;
        rd_hazard  = 1'b0;
        if (issue_rs1_used) begin
            rs1_hazard = issue_rs1_f ? fbusy_q[issue_rs1] : gbusy_q[issue_rs1];
        end
        if (issue_rs2_used) begin
            rs2_hazard = issue_rs2_f ? fbusy_q[issue_rs2] : gbusy_q[issue_rs2];
        end
        if (issue_rd_used) begin
            rd_hazard = issue_rd_f ? fbusy_q[issue_rd] : gbusy_q[issue_rd];
        end
        issue_ready = ~(rs1_hazard | rs2_hazard | rd_hazard);
        issue_fire  = issue_valid & issue_ready;
    end

    // Fixed priority: MEM beats FPU beats ALU.
    always_comb begin
        fixed_grant = 3'b000;
        if (wb_valid[2]) begin
            fixed_grant = 3'b100;
        end else if (wb_valid[1]) begin
            fixed_grant = 3'b010;
        end else if (wb_valid[0]) begin
            fixed_grant = 3'b001;
        end
    end

    // Round-robin: priority descends cyclically starting at the pointer.
    always_comb begin
        rr_grant = 3'b000;
        case (rr_ptr_q)
            2'd1: begin
                if (wb_valid[1])      rr_grant = 3'b010;
                else if (wb_valid[2]) rr_grant = 3'b100;
                else if (wb_valid[0]) rr_grant = 3'b001;
            end
            2'd2: begin
                if (wb_valid[2])      rr_grant = 3'b100;
                else if (wb_valid[0]) rr_grant = 3'b001;
                else if (wb_valid[1]) rr_grant = 3'b010;
            end
            default: begin
                if (wb_valid[0])      rr_grant = 3'b001;
                else if (wb_valid[1]) rr_grant = 3'b010;
                else if (wb_valid[2]) rr_grant = 3'b100;
            end
        endcase
    end

    // Pick the arbitration flavour and extract the winning requester's payload.
    always_comb begin
        wb_grant  = (ROUND_ROBIN != 0) ? rr_grant : fixed_grant;
        grant_any = 1'b1;
        grant_idx = 2'd0;
        sel_f     = 1'b0;
        sel_reg   = 5'd0;
        sel_data  = 32'd0;
        case (wb_grant)
            3'b001: begin
                grant_idx = 2'd0;
                sel_f     = wb_f[0];
                sel_reg   = wb_reg[4:0];
                sel_data  = wb_data[31:0];
            end
            3'b010: begin
                grant_idx = 2'd1;
                sel_f     = wb_f[1];
                sel_reg   = wb_reg[9:5];
                sel_data  = wb_data[63:32];
            end
            3'b100: begin
                grant_idx = 2'd2;
                sel_f     = wb_f[2];
                sel_reg   = wb_reg[14:10];
                sel_data  = wb_data[95:64];
            end
            default: begin
                grant_any = 1'b0;
            end
        endcase
    end

    // Next pointer: one past the winner, holding when nothing was granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((ROUND_ROBIN != 0) && grant_any) begin
            case (grant_idx)
                2'd0:    rr_ptr_d = 2'd1;
                2'd1:    rr_ptr_d = 2'd2;
                default: rr_ptr_d = 2'd0;
            endcase
        end
    end

    // Next write-port contents: load the winner, or drop enable and hold payload.
    // A write to integer register 0 is accepted but never enabled.
    always_comb begin
        rf_wenable_d = 1'b0;
        rf_wfmode_d  = rf_wfmode_q;
        rf_wreg_d    = rf_wreg_q;
        rf_wdata_d   = rf_wdata_q;
        if (grant_any) begin
            rf_wenable_d = sel_f | (sel_reg != 5'd0);
            rf_wfmode_d  = sel_f;
            rf_wreg_d    = sel_reg;
            rf_wdata_d   = sel_data;
        end
    end

    // Busy update: clear the register being written this cycle, then set the
    // newly issued destination so that a coincident set takes precedence.
    always_comb begin
        gbusy_d = gbusy_q;
        fbusy_d = fbusy_q;
        if (rf_wenable_q) begin
            if (rf_wfmode_q) begin
                fbusy_d[rf_wreg_q] = 1'b0;
            end else begin
                gbusy_d[rf_wreg_q] = 1'b0;
            end
        end
        if (issue_fire && issue_rd_used) begin
            if (issue_rd_f) begin
                fbusy_d[issue_rd] = 1'b1;
            end else if (issue_rd != 5'd0) begin
                gbusy_d[issue_rd] = 1'b1;
            end
        end
        gbusy_d[0] = 1'b0;
        idle_d = (gbusy_d == 32'd0) && (fbusy_d == 32'd0) && !rf_wenable_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gbusy_q      <= 32'd0;
            fbusy_q      <= 32'd0;
            rr_ptr_q     <= 2'd0;
            rf_wenable_q <= 1'b0;
            rf_wfmode_q  <= 1'b0;
            rf_wreg_q    <= 5'd0;
            rf_wdata_q   <= 32'd0;
            idle_q       <= 1'b1;
        end else begin
            gbusy_q      <= gbusy_d;
            fbusy_q      <= fbusy_d;
            rr_ptr_q     <= rr_ptr_d;
            rf_wenable_q <= rf_wenable_d;
            rf_wfmode_q  <= rf_wfmode_d;
            rf_wreg_q    <= rf_wreg_d;
            rf_wdata_q   <= rf_wdata_d;
            idle_q       <= idle_d;
        end
    end

    assign rf_wenable = rf_wenable_q;
    assign rf_wfmode  = rf_wfmode_q;
    assign rf_wreg    = rf_wreg_q;
    assign rf_wdata   = rf_wdata_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a fixed-priority and a round-robin instance
// share the issue stream; each has its own write-back requesters. A
// behavioural model predicts every output each cycle, and directed scenarios
// add hand-computed expectations.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rs1_f, issue_rs2_f, issue_rd_f;
    logic        issue_rs1_used, issue_rs2_used, issue_rd_used;

    logic [2:0]  wbv   [2];
    logic [2:0]  wbf   [2];
    logic [14:0] wbr   [2];
    logic [95:0] wbd   [2];
    logic        ready [2];
    logic [2:0]  grant [2];
    logic        wen   [2];
    logic        wfm   [2];
    logic [4:0]  wreg  [2];
    logic [31:0] wdata [2];
    logic        idl   [2];

    regfile_scoreboard #(.ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_f(issue_rs1_f), .issue_rs2_f(issue_rs2_f),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_f(issue_rd_f), .issue_rd_used(issue_rd_used),
        .issue_ready(ready[0]),
        .wb_valid(wbv[0]), .wb_f(wbf[0]), .wb_reg(wbr[0]), .wb_data(wbd[0]),
        .wb_grant(grant[0]),
        .rf_wenable(wen[0]), .rf_wfmode(wfm[0]), .rf_wreg(wreg[0]), .rf_wdata(wdata[0]),
        .idle(idl[0])
    );

    regfile_scoreboard #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_f(issue_rs1_f), .issue_rs2_f(issue_rs2_f),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_f(issue_rd_f), .issue_rd_used(issue_rd_used),
        .issue_ready(ready[1]),
        .wb_valid(wbv[1]), .wb_f(wbf[1]), .wb_reg(wbr[1]), .wb_data(wbd[1]),
        .wb_grant(grant[1]),
        .rf_wenable(wen[1]), .rf_wfmode(wfm[1]), .rf_wreg(wreg[1]), .rf_wdata(wdata[1]),
        .idle(idl[1])
    );

    // Behavioural model state (index 0 = fixed priority, 1 = round robin).
    logic [31:0] m_gb    [2] = '{32'd0, 32'd0};
    logic [31:0] m_fb    [2] = '{32'd0, 32'd0};
    int          m_ptr   [2] = '{0, 0};
    logic        m_wen   [2] = '{1'b0, 1'b0};
    logic        m_wf    [2] = '{1'b0, 1'b0};
    logic [4:0]  m_wreg  [2] = '{5'd0, 5'd0};
    logic [31:0] m_wdata [2] = '{32'd0, 32'd0};
    logic        m_idle  [2] = '{1'b1, 1'b1};

    // Pending write-back requests per instance and requester.
    bit          p_v [2][3];
    logic        p_f [2][3];
    logic [4:0]  p_r [2][3];
    logic [31:0] p_d [2][3];

    int n_checks = 0;
    int n_errors = 0;
    bit checks_on = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at t=%0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic m_busy(input int i, input logic f, input logic [4:0] r);
        if (f) return m_fb[i][r];
        if (r == 5'd0) return 1'b0;
        return m_gb[i][r];
    endfunction

    function automatic logic m_ready(input int i);
        logic hz;
        hz = 1'b0;
        if (issue_rs1_used && m_busy(i, issue_rs1_f, issue_rs1)) hz = 1'b1;
        if (issue_rs2_used && m_busy(i, issue_rs2_f, issue_rs2)) hz = 1'b1;
        if (issue_rd_used  && m_busy(i, issue_rd_f,  issue_rd))  hz = 1'b1;
        return !hz;
    endfunction

    function automatic logic [2:0] m_grant(input int i);
        logic [2:0] g;
        int k;
        g = 3'b000;
        if (i == 0) begin
            for (int n = 2; n >= 0; n--) begin
                if (g == 3'b000 && wbv[0][n]) g[n] = 1'b1;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                k = (m_ptr[1] + n) % 3;
                if (g == 3'b000 && wbv[1][k]) g[k] = 1'b1;
            end
        end
        return g;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic m_step();
        logic [2:0] g;
        logic fire;
        for (int i = 0; i < 2; i++) begin
            g    = m_grant(i);
            fire = issue_valid && m_ready(i);
            if (!rstn) begin
                m_gb[i] = 32'd0; m_fb[i] = 32'd0; m_ptr[i] = 0;
                m_wen[i] = 1'b0; m_wf[i] = 1'b0; m_wreg[i] = 5'd0; m_wdata[i] = 32'd0;
                m_idle[i] = 1'b1;
            end else begin
                if (m_wen[i]) begin
                    if (m_wf[i]) m_fb[i][m_wreg[i]] = 1'b0;
                    else         m_gb[i][m_wreg[i]] = 1'b0;
                end
                if (fire && issue_rd_used && (issue_rd_f || issue_rd != 5'd0)) begin
                    if (issue_rd_f) m_fb[i][issue_rd] = 1'b1;
                    else            m_gb[i][issue_rd] = 1'b1;
                end
                m_wen[i] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (g[k]) begin
                        m_wf[i]    = wbf[i][k];
                        m_wreg[i]  = wbr[i][5*k +: 5];
                        m_wdata[i] = wbd[i][32*k +: 32];
                        m_wen[i]   = wbf[i][k] || (wbr[i][5*k +: 5] != 5'd0);
                        if (i == 1) m_ptr[1] = (k + 1) % 3;
                    end
                end
                m_idle[i] = (m_gb[i] == 32'd0) && (m_fb[i] == 32'd0) && !m_wen[i];
            end
            for (int k = 0; k < 3; k++) begin
                if (g[k]) p_v[i][k] = 1'b0;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                wbv[i][k]          = p_v[i][k];
                wbf[i][k]          = p_f[i][k];
                wbr[i][5*k +: 5]   = p_r[i][k];
                wbd[i][32*k +: 32] = p_d[i][k];
            end
        end
    endtask

    // One clock cycle: compare combinational outputs, advance model at the edge,
    // then compare registered outputs.
    task automatic tick();
        drive_inputs();
        #1;
        if (checks_on) begin
            for (int i = 0; i < 2; i++) begin
                check_output($sformatf("issue_ready[%0d]", i), 32'(ready[i]), 32'(m_ready(i)));
                check_output($sformatf("wb_grant[%0d]", i), 32'(grant[i]), 32'(m_grant(i)));
            end
        end
        @(posedge clk);
        m_step();
        checks_on = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("rf_wenable[%0d]", i), 32'(wen[i]),  32'(m_wen[i]));
            check_output($sformatf("rf_wfmode[%0d]", i),  32'(wfm[i]),  32'(m_wf[i]));
            check_output($sformatf("rf_wreg[%0d]", i),    32'(wreg[i]), 32'(m_wreg[i]));
            check_output($sformatf("rf_wdata[%0d]", i),   wdata[i],     m_wdata[i]);
            check_output($sformatf("idle[%0d]", i),       32'(idl[i]),  32'(m_idle[i]));
        end
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic v,
                                  input logic [4:0] r1, input logic f1, input logic u1,
                                  input logic [4:0] r2, input logic f2, input logic u2,
                                  input logic [4:0] rd, input logic fd, input logic ud);
        issue_valid = v;
        issue_rs1 = r1; issue_rs1_f = f1; issue_rs1_used = u1;
        issue_rs2 = r2; issue_rs2_f = f2; issue_rs2_used = u2;
        issue_rd  = rd; issue_rd_f  = fd; issue_rd_used  = ud;
    endtask

    task automatic post_one(input int i, input int k, input logic f, input logic [4:0] r, input logic [31:0] d);
        p_v[i][k] = 1'b1; p_f[i][k] = f; p_r[i][k] = r; p_d[i][k] = d;
    endtask

    task automatic post_both(input int k, input logic f, input logic [4:0] r, input logic [31:0] d);
        post_one(0, k, f, r, d);
        post_one(1, k, f, r, d);
    endtask

    function automatic bit any_pending();
        bit a;
        a = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                if (p_v[i][k]) a = 1'b1;
        return a || m_wen[0] || m_wen[1];
    endfunction

    // Run until all requests retire, with a bounded cycle budget.
    task automatic drain();
        int cnt;
        cnt = 0;
        while (any_pending() && cnt < 30) begin
            tick();
            cnt++;
        end
        check_output("drain_timeout", 32'(any_pending()), 32'd0);
    endtask

    logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rstn = 1'b0;
        apply_stimulus(0, 0,0,0, 0,0,0, 0,0,0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) begin
                p_v[i][k] = 1'b0; p_f[i][k] = 1'b0; p_r[i][k] = 5'd0; p_d[i][k] = 32'd0;
            end
        drive_inputs();
        @(negedge clk);
        tick();
        tick();
        check_output("reset_idle_fixed", 32'(idl[0]), 32'd1);
        check_output("reset_idle_rr", 32'(idl[1]), 32'd1);
        check_output("reset_wen_fixed", 32'(wen[0]), 32'd0);
        rstn = 1'b1;

        // Round-robin order with all three requesters kept asserted.
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 3; k++)
                if (!p_v[1][k]) post_one(1, k, 1'b0, 5'(20 + k), 32'(c * 16 + k));
            drive_inputs();
            #1;
            check_output($sformatf("rr_order_%0d", c), 32'(grant[1]), 32'(rr_exp[c]));
            tick();
        end
        drain();

        // Fixed priority MEM > FPU > ALU; write port follows one cycle later.
        post_both(0, 1'b0, 5'd10, 32'h1000_000A);
        post_both(1, 1'b1, 5'd11, 32'h1000_000B);
        post_both(2, 1'b0, 5'd12, 32'h1000_000C);
        drive_inputs(); #1;
        check_output("prio_grant_mem", 32'(grant[0]), 32'b100);
        tick();
        check_output("prio_wreg_mem", 32'(wreg[0]), 32'd12);
        drive_inputs(); #1;
        check_output("prio_grant_fpu", 32'(grant[0]), 32'b010);
        tick();
        check_output("prio_wreg_fpu", 32'(wreg[0]), 32'd11);
        check_output("prio_wfmode_fpu", 32'(wfm[0]), 32'd1);
        drive_inputs(); #1;
        check_output("prio_grant_alu", 32'(grant[0]), 32'b001);
        tick();
        check_output("prio_wreg_alu", 32'(wreg[0]), 32'd10);
        check_output("prio_wdata_alu", wdata[0], 32'h1000_000A);
        drain();

        // RAW on g3: blocked until two cycles after its grant.
        apply_stimulus(1, 0,0,0, 0,0,0, 5'd3,0,1);
        #1 check_output("raw_first_ready", 32'(ready[0]), 32'd1);
        tick();
        apply_stimulus(1, 5'd3,0,1, 0,0,0, 0,0,0);
        #1 check_output("raw_blocked", 32'(ready[0]), 32'd0);
        tick();
        post_both(0, 1'b0, 5'd3, 32'hA5A5_0003);
        drive_inputs(); #1;
        check_output("raw_grant_cycle_ready", 32'(ready[0]), 32'd0);
        check_output("raw_grant_alu", 32'(grant[0]), 32'b001);
        tick();
        check_output("raw_wen", 32'(wen[0]), 32'd1);
        check_output("raw_wreg", 32'(wreg[0]), 32'd3);
        drive_inputs(); #1;
        check_output("raw_no_bypass", 32'(ready[1]), 32'd0);
        tick();
        #1 check_output("raw_released", 32'(ready[0]), 32'd1);
        tick();
        apply_stimulus(0, 0,0,0, 0,0,0, 0,0,0);

        // Integer register zero is never busy and never written.
        apply_stimulus(1, 0,0,0, 0,0,0, 5'd0,0,1);
        #1 check_output("g0_rd_ready", 32'(ready[0]), 32'd1);
        tick();
        apply_stimulus(1, 5'd0,0,1, 0,0,0, 5'd0,0,1);
        #1 check_output("g0_rs_ready", 32'(ready[0]), 32'd1);
        tick();
        apply_stimulus(0, 0,0,0, 0,0,0, 0,0,0);
        post_both(0, 1'b0, 5'd0, 32'hDEAD_BEEF);
        drive_inputs(); #1;
        check_output("g0_grant", 32'(grant[0]), 32'b001);
        tick();
        check_output("g0_wen", 32'(wen[0]), 32'd0);
        check_output("g0_idle", 32'(idl[0]), 32'd1);

        // File separation: f7 busy does not block g7.
        apply_stimulus(1, 0,0,0, 0,0,0, 5'd7,1,1);
        tick();
        check_output("fsep_not_idle", 32'(idl[0]), 32'd0);
        apply_stimulus(0, 5'd7,0,1, 0,0,0, 0,0,0);
        #1 check_output("fsep_g7_ready", 32'(ready[0]), 32'd1);
        apply_stimulus(0, 0,0,0, 5'd7,1,1, 0,0,0);
        #1 check_output("fsep_f7_blocked", 32'(ready[1]), 32'd0);
        post_both(1, 1'b1, 5'd7, 32'h0000_F007);
        drain();
        tick();
        #1 check_output("fsep_f7_released", 32'(ready[0]), 32'd1);

        // Reset mid-flight discards busy state and any pending write.
        apply_stimulus(1, 0,0,0, 0,0,0, 5'd4,0,1);
        tick();
        apply_stimulus(1, 0,0,0, 0,0,0, 5'd9,1,1);
        tick();
        apply_stimulus(0, 0,0,0, 0,0,0, 0,0,0);
        post_both(2, 1'b1, 5'd9, 32'h0000_0909);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_output("midreset_idle", 32'(idl[0]), 32'd1);
        check_output("midreset_wen", 32'(wen[1]), 32'd0);
        apply_stimulus(0, 5'd4,0,1, 5'd9,1,1, 5'd4,0,1);
        #1 check_output("midreset_ready_fixed", 32'(ready[0]), 32'd1);
        check_output("midreset_ready_rr", 32'(ready[1]), 32'd1);
        tick();
        tick();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter ROUND_ROBIN, default 0, 0 = fixed-priority write-port arbitration, 1 = round-robin.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 issue_valid  in  1  decoded instruction presented for issue.
REQ-005 issue_rs1, issue_rs2  in  5 each  source register indices.
REQ-006 issue_rs1_f, issue_rs2_f  in  1 each  source is FP file (1) or integer file (0).
REQ-007 issue_rs1_used, issue_rs2_used  in  1 each  source operand actually read.
REQ-008 issue_rd  in  5  destination index; issue_rd_f  in  1  destination file; issue_rd_used  in  1  instruction writes rd.
REQ-009 issue_ready  out  1  combinational; instruction may issue this cycle.
REQ-010 wb_valid  in  3  per-requester write request, bit 0 = ALU, 1 = FPU, 2 = MEM.
REQ-011 wb_f  in  3, wb_reg  in  15 (5 per requester), wb_data  in  96 (32 per requester).
REQ-012 wb_grant  out  3  combinational one-hot; at most one bit set.
REQ-013 rf_wenable, rf_wfmode  out  1 each; rf_wreg  out  5; rf_wdata  out  32; registered; drive the register-file write port directly.
REQ-014 idle  out  1  registered; no busy bit set and rf_wenable = 0.

Function
REQ-015 The block SHALL hold 64 busy bits: 32 integer (gbusy) and 32 FP (fbusy); gbusy[0] SHALL always read 0 and never be set.
REQ-016 issue_ready SHALL be 1 iff no used source is busy in its file (RAW) and, when issue_rd_used, the destination is not busy (WAW); unused operands are ignored.
REQ-017 Issue fires when issue_valid & issue_ready; on fire with issue_rd_used, the destination busy bit SHALL be set at the next edge, except integer rd = 0.
REQ-018 issue_ready SHALL depend only on current busy state; no bypass from a same-cycle write-back clear.
REQ-019 Arbitration with ROUND_ROBIN = 0: fixed priority MEM > FPU > ALU among asserted wb_valid bits.
REQ-020 Arbitration with ROUND_ROBIN = 1: a 2-bit pointer (values 0..2) names the highest-priority requester, with priority descending cyclically from it; after any grant the pointer SHALL become (granted index + 1) mod 3; with no grant the pointer holds.
REQ-021 A requester holds wb_valid and its payload stable until granted; a grant completes its transfer in that cycle.
REQ-022 On a grant, the next edge SHALL load rf_wenable = 1, rf_wfmode = wb_f, rf_wreg = wb_reg, and rf_wdata = wb_data of the granted requester.
REQ-023 A grant carrying integer register 0 SHALL be granted but SHALL load rf_wenable = 0.
REQ-024 With no grant, the next edge SHALL load rf_wenable = 0; rf_wfmode, rf_wreg and rf_wdata hold their values.
REQ-025 Write-back latency is 1 cycle: grant in cycle N, rf_wenable = 1 in cycle N+1, register-file write at the end of N+1.
REQ-026 The busy bit of the write target SHALL clear at the edge ending the cycle in which rf_wenable = 1, so dependents see issue_ready = 1 in cycle N+2.
REQ-027 Same-register set and clear in one cycle cannot occur, because of REQ-016 WAW; if it occurs, set SHALL win.
REQ-028 A write-back to a non-busy register SHALL still be performed, and the busy state stays 0.
REQ-029 Busy bits of the integer and FP files are independent: g5 busy SHALL NOT block an f5 read.

Reset
REQ-030 With rstn = 0 at an edge: all busy bits 0, rf_wenable 0, rf_wfmode 0, rf_wreg 0, rf_wdata 0, round-robin pointer 0, idle 1.
REQ-031 Reset mid-operation SHALL discard pending busy state; wb_grant is still combinational during reset, but no write SHALL reach rf_* until rstn = 1.

Verification
REQ-032 RAW: issue rd = g3; next cycle issue rs1 = g3 -> issue_ready = 0 until 2 cycles after the ALU grant for g3, then 1.
REQ-033 Priority (ROUND_ROBIN = 0): wb_valid = 3'b111 -> wb_grant = 3'b100, then 3'b010, then 3'b001 on successive cycles; rf_wreg follows one cycle later.
REQ-034 Round-robin (ROUND_ROBIN = 1): wb_valid held at 3'b111 for 6 cycles -> grant order ALU, FPU, MEM, ALU, FPU, MEM.
REQ-035 Zero register: issue rd = g0 -> gbusy stays 0 and issue_ready stays 1; a write-back to g0 -> wb_grant asserted, rf_wenable = 0.
REQ-036 File separation: f7 busy, issue rs1 = g7 integer -> issue_ready = 1; issue rs2 = f7 FP -> 0.
REQ-037 Reset mid-flight: g4 and f9 busy, rstn = 0 for 1 cycle -> idle = 1, issue_ready = 1 for any operands.
